// File: rtl/word_boundary_detector_if.sv
// Sample-stream and word-report bundle for word_boundary_detector.
// isample_valid qualifies isample for one cycle with no ready/backpressure; ovalid is a one-cycle pulse qualifying the held address pair.
interface word_boundary_detector_if;
    logic               isample_valid;
    logic signed [15:0] isample;
    logic        [31:0] ithresh;
    logic               ovalid;
    logic        [31:0] ostart_addr;
    logic        [31:0] oend_addr;
    logic               obusy;
    logic        [1:0]  ostate;

    modport master (
        output isample_valid, isample, ithresh,
        input  ovalid, ostart_addr, oend_addr, obusy, ostate
    );

    modport slave (
        input  isample_valid, isample, ithresh,
        output ovalid, ostart_addr, oend_addr, obusy, ostate
    );
endinterface

// File: rtl/word_boundary_detector.sv
// Frame-energy voice activity detector: finds word start/end sample addresses
// using onset confirmation, hangover bridging and a maximum word length.
module word_boundary_detector #(
    parameter int FRAME_LEN  = 256,
    parameter int ON_FRAMES  = 3,
    parameter int OFF_FRAMES = 8,
    parameter int MAX_FRAMES = 64
) (
    input  logic                  iclk,
    input  logic                  irst,
    word_boundary_detector_if.slave wbd
);
    localparam int SW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int FW = $clog2(MAX_FRAMES + 1);
    localparam int NW = $clog2(ON_FRAMES + 1);
    localparam int OW = $clog2(OFF_FRAMES + 1);

    localparam logic [SW-1:0] SAMP_LAST = SW'(FRAME_LEN - 1);
    localparam logic [FW-1:0] MAX_CNT   = FW'(MAX_FRAMES);
    localparam logic [NW-1:0] ON_CNT    = NW'(ON_FRAMES);
    localparam logic [OW-1:0] OFF_CNT   = OW'(OFF_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ONSET = 2'd1,
        ST_WORD  = 2'd2,
        ST_HANG  = 2'd3
    } state_t;

    state_t        state;
    logic [31:0]   addr_cnt;
    logic [31:0]   acc;
    logic [SW-1:0] samp_cnt;
    logic [31:0]   frame_base;
    logic [FW-1:0] frame_cnt;
    logic [NW-1:0] on_cnt;
    logic [OW-1:0] off_cnt;
    logic [31:0]   cand_start;
    logic [31:0]   cand_end;
    logic          ovalid_q;
    logic [31:0]   ostart_q;
    logic [31:0]   oend_q;

    logic [16:0]   mag;
    logic [31:0]   energy;
    logic          speech;
    logic          frame_done;
    logic [FW-1:0] frame_cnt_nxt;
    logic [NW-1:0] on_cnt_nxt;
    logic [OW-1:0] off_cnt_nxt;
    logic          force_end;
    logic          word_done;
    logic [31:0]   done_end;

    // Two's-complement magnitude; -32768 needs the 17th bit.
    assign mag = wbd.isample[15] ? (17'd0 - {1'b1, wbd.isample}) : {1'b0, wbd.isample};

    assign energy        = acc + {15'd0, mag};
    assign speech        = energy > wbd.ithresh;
    assign frame_done    = wbd.isample_valid && (samp_cnt == SAMP_LAST);
    assign frame_cnt_nxt = frame_cnt + FW'(1);
    assign on_cnt_nxt    = on_cnt + NW'(1);
    assign off_cnt_nxt   = off_cnt + OW'(1);
    assign force_end     = (frame_cnt_nxt == MAX_CNT);

    // Word termination: max length wins over hangover expiry.
    always_comb begin
        word_done = 1'b0;
        done_end  = cand_end;
        if (frame_done) begin
            unique case (state)
                ST_WORD: begin
                    if (force_end) begin
                        word_done = 1'b1;
                        done_end  = speech ? addr_cnt : cand_end;
                    end else if (!speech && (OFF_FRAMES == 1)) begin
                        word_done = 1'b1;
                    end
                end
                ST_HANG: begin
                    if (force_end) begin
                        word_done = 1'b1;
                        done_end  = speech ? addr_cnt : cand_end;
                    end else if (!speech && (off_cnt_nxt == OFF_CNT)) begin
                        word_done = 1'b1;
                    end
                end
                default: begin
                    word_done = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state      <= ST_IDLE;
            addr_cnt   <= '0;
            acc        <= '0;
            samp_cnt   <= '0;
            frame_base <= '0;
            frame_cnt  <= '0;
            on_cnt     <= '0;
            off_cnt    <= '0;
            cand_start <= '0;
            cand_end   <= '0;
            ovalid_q   <= 1'b0;
            ostart_q   <= '0;
            oend_q     <= '0;
        end else begin
            ovalid_q <= 1'b0;
            if (wbd.isample_valid) begin
                addr_cnt <= addr_cnt + 32'd1;
                samp_cnt <= samp_cnt + SW'(1);
                acc      <= frame_done ? 32'd0 : energy;
                if (samp_cnt == '0) begin
                    frame_base <= addr_cnt;
                end
                if (frame_done) begin
                    if (word_done) begin
                        ovalid_q  <= 1'b1;
                        ostart_q  <= cand_start;
                        oend_q    <= done_end;
                        state     <= ST_IDLE;
                        frame_cnt <= '0;
                        on_cnt    <= '0;
                        off_cnt   <= '0;
                    end else begin
                        unique case (state)
                            ST_IDLE: begin
                                if (speech) begin
                                    cand_start <= frame_base;
                                    cand_end   <= addr_cnt;
                                    frame_cnt  <= FW'(1);
                                    on_cnt     <= NW'(1);
                                    off_cnt    <= '0;
                                    state      <= (ON_FRAMES == 1) ? ST_WORD : ST_ONSET;
                                end
                            end
                            ST_ONSET: begin
                                if (speech) begin
                                    cand_end  <= addr_cnt;
                                    on_cnt    <= on_cnt_nxt;
                                    frame_cnt <= frame_cnt_nxt;
                                    if (on_cnt_nxt == ON_CNT) begin
                                        state <= ST_WORD;
                                    end
                                end else begin
                                    state     <= ST_IDLE;
                                    frame_cnt <= '0;
                                    on_cnt    <= '0;
                                end
                            end
                            ST_WORD: begin
                                frame_cnt <= frame_cnt_nxt;
                                if (speech) begin
                                    cand_end <= addr_cnt;
                                end else begin
                                    off_cnt <= OW'(1);
                                    state   <= ST_HANG;
                                end
                            end
                            ST_HANG: begin
                                frame_cnt <= frame_cnt_nxt;
                                if (speech) begin
                                    cand_end <= addr_cnt;
                                    off_cnt  <= '0;
                                    state    <= ST_WORD;
                                end else begin
                                    off_cnt <= off_cnt_nxt;
                                end
                            end
                        endcase
                    end
                end
            end
        end
    end

    assign wbd.ovalid      = ovalid_q;
    assign wbd.ostart_addr = ostart_q;
    assign wbd.oend_addr   = oend_q;
    assign wbd.obusy       = (state != ST_IDLE);
    assign wbd.ostate      = state;
endmodule

// File: tb/tb_word_boundary_detector.sv
// Bench for word_boundary_detector: directed scenarios plus randomized stalls,
// checked cycle by cycle against a frame-index reference model.
module tb_word_boundary_detector;
  localparam int FL   = 4;
  localparam int ONF  = 2;
  localparam int OFFF = 2;
  localparam int MAXF = 8;

  logic iclk = 1'b0;
  logic irst;
  word_boundary_detector_if wbd_if ();

  word_boundary_detector #(
    .FRAME_LEN (FL),
    .ON_FRAMES (ONF),
    .OFF_FRAMES(OFFF),
    .MAX_FRAMES(MAXF)
  ) dut (
    .iclk(iclk),
    .irst(irst),
    .wbd (wbd_if)
  );

  always #5 iclk = ~iclk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: works in frame indices since the last reset
  longint      m_nacc;
  longint      m_energy;
  int          m_cand;
  int          m_last;
  logic [31:0] exp_q[$];
  logic [31:0] hold_start;
  logic [31:0] hold_end;
  int          n_emit;
  longint      emit_at;
  int          busy_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] faddr(input int f);
    return 32'(longint'(f) * FL);
  endfunction

  task automatic model_reset();
    m_nacc = 0; m_energy = 0; m_cand = -1; m_last = -1;
    exp_q.delete();
    hold_start = '0; hold_end = '0;
    n_emit = 0; emit_at = -1; busy_cycles = 0;
  endtask

  task automatic model_emit(input int last_frame);
    exp_q.push_back(faddr(m_cand));
    exp_q.push_back(faddr(last_frame) + 32'(FL - 1));
    m_cand = -1;
  endtask

  task automatic model_accept(input logic signed [15:0] s, input logic [31:0] th, output bit emit);
    int k;
    bit sp;
    emit = 1'b0;
    m_energy += (s < 0) ? -longint'(s) : longint'(s);
    m_nacc++;
    if (m_nacc % FL == 0) begin
      k  = int'(m_nacc / FL) - 1;
      sp = (m_energy > longint'({32'd0, th}));
      m_energy = 0;
      if (m_cand < 0) begin
        if (sp) begin m_cand = k; m_last = k; end
      end else if (m_cand + ONF - 1 > k - 1) begin
        if (sp) m_last = k; else m_cand = -1;
      end else if (k - m_cand + 1 == MAXF) begin
        model_emit(sp ? k : m_last);
        emit = 1'b1;
      end else if (sp) begin
        m_last = k;
      end else if (k - m_last == OFFF) begin
        model_emit(m_last);
        emit = 1'b1;
      end
    end
  endtask

  task automatic step(input bit v, input logic signed [15:0] s);
    bit emit;
    @(negedge iclk);
    wbd_if.isample_valid = v;
    wbd_if.isample       = s;
    @(posedge iclk);
    emit = 1'b0;
    if (v) model_accept(s, wbd_if.ithresh, emit);
    if (emit) begin
      hold_start = exp_q.pop_front();
      hold_end   = exp_q.pop_front();
    end
    #1;
    check("ovalid", 32'(wbd_if.ovalid), 32'(emit));
    check("obusy", 32'(wbd_if.obusy), 32'(m_cand >= 0));
    check("ostart_addr", wbd_if.ostart_addr, hold_start);
    check("oend_addr", wbd_if.oend_addr, hold_end);
    if (wbd_if.ovalid) begin n_emit++; emit_at = m_nacc - 1; end
    if (wbd_if.obusy) busy_cycles++;
  endtask

  task automatic frame(input logic signed [15:0] s);
    for (int i = 0; i < FL; i++) step(1'b1, s);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge iclk);
      irst = 1'b1;
      wbd_if.isample_valid = 1'b1;
      wbd_if.isample       = 16'($urandom);
    end
    @(negedge iclk);
    irst = 1'b0;
    wbd_if.isample_valid = 1'b0;
    model_reset();
    check("rst_ovalid", 32'(wbd_if.ovalid), 32'd0);
    check("rst_obusy", 32'(wbd_if.obusy), 32'd0);
    check("rst_start", wbd_if.ostart_addr, 32'd0);
    check("rst_end", wbd_if.oend_addr, 32'd0);
  endtask

  initial begin
    int kind;
    logic signed [15:0] s;
    irst = 1'b1;
    wbd_if.isample_valid = 1'b0;
    wbd_if.isample       = '0;
    wbd_if.ithresh       = 32'd100;
    model_reset();

    // reset, then a basic three-frame word
    do_reset(2);
    frame(0); frame(0);
    frame(1000); frame(1000); frame(1000);
    frame(0); frame(0);
    check("basic_emits", 32'(n_emit), 32'd1);
    check("basic_emit_at", 32'(emit_at), 32'd27);
    check("basic_start", wbd_if.ostart_addr, 32'd8);
    check("basic_end", wbd_if.oend_addr, 32'd19);

    // single-frame blip, then an at-threshold frame
    do_reset(2);
    frame(-1000);
    for (int i = 0; i < 4; i++) frame(0);
    check("blip_emits", 32'(n_emit), 32'd0);
    check("blip_busy", 32'(busy_cycles), 32'(FL));
    frame(25);
    check("thresh_eq_busy", 32'(busy_cycles), 32'(FL));

    // one-frame gap bridged by hangover
    do_reset(2);
    frame(1000); frame(1000); frame(0); frame(1000); frame(0); frame(0);
    check("gap_emits", 32'(n_emit), 32'd1);
    check("gap_start", wbd_if.ostart_addr, 32'd0);
    check("gap_end", wbd_if.oend_addr, 32'd15);

    // forced end at MAX frames, then a fresh onset
    do_reset(2);
    for (int i = 0; i < 8; i++) frame(1000);
    check("force_emits", 32'(n_emit), 32'd1);
    check("force_emit_at", 32'(emit_at), 32'd31);
    check("force_start", wbd_if.ostart_addr, 32'd0);
    check("force_end", wbd_if.oend_addr, 32'd31);
    frame(1000); frame(1000); frame(0); frame(0);
    check("reonset_emits", 32'(n_emit), 32'd2);
    check("reonset_start", wbd_if.ostart_addr, 32'd32);
    check("reonset_end", wbd_if.oend_addr, 32'd39);

    // reset in the middle of a word drops it
    do_reset(2);
    frame(1000); frame(1000); frame(1000);
    do_reset(2);
    frame(0); frame(0);
    check("midrst_emits", 32'(n_emit), 32'd0);
    frame(1000); frame(1000); frame(0); frame(0);
    check("postrst_start", wbd_if.ostart_addr, 32'd8);
    check("postrst_end", wbd_if.oend_addr, 32'd15);

    // randomized stalls, extremes and near-threshold frames
    do_reset(2);
    for (int f = 0; f < 200; f++) begin
      kind = $urandom_range(0, 3);
      wbd_if.ithresh = 32'($urandom_range(90, 110));
      for (int i = 0; i < FL; i++) begin
        while ($urandom_range(0, 2) == 0) step(1'b0, 16'($urandom));
        case (kind)
          0: s = 16'($urandom_range(0, 20)) - 16'sd10;
          1: s = ($urandom_range(0, 2) == 0) ? -16'sd32768 : 16'($urandom);
          2: s = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(20, 30)) : -16'($urandom_range(20, 30));
          default: s = -16'sd32768;
        endcase
        step(1'b1, s);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/word_boundary_detector.md
WORD_BOUNDARY_DETECTOR -- requirements
Module: word_boundary_detector

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 256, samples per analysis frame (power of 2, 2..32768).
REQ-002 SHALL have parameter ON_FRAMES, default 3, consecutive speech frames needed to confirm a word (>=1).
REQ-003 SHALL have parameter OFF_FRAMES, default 8, consecutive silence frames needed to end a word (>=1).
REQ-004 SHALL have parameter MAX_FRAMES, default 64, frames from word start at which a word is force-ended (> ON_FRAMES).
REQ-005 iclk  input  1  sole clock; all state changes on its rising edge.
REQ-006 irst  input  1  reset, synchronous, active-high.
REQ-007 isample_valid  input  1  one audio sample is presented this cycle.
REQ-008 isample  input  16  signed two's-complement audio sample.
REQ-009 ithresh  input  32  frame energy threshold, unsigned, sampled at each frame decision.
REQ-010 ovalid  output  1  single-cycle pulse; ostart_addr and oend_addr are valid. Feeds downstream ivalid.
REQ-011 ostart_addr  output  32  sample address of the word's first sample.
REQ-012 oend_addr  output  32  sample address of the word's last sample.
REQ-013 obusy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL keep a 32-bit sample address counter: each accepted sample takes the current value, then the counter increments, wrapping 0xFFFFFFFF->0.
REQ-015 SHALL accumulate |isample| per frame in a 32-bit accumulator; |-32768| = 32768; no saturation needed.
REQ-016 A frame decision SHALL occur on the edge accepting the FRAME_LEN-th sample of the frame, using acc+|isample| including that sample; the accumulator clears on the same edge.
REQ-017 A frame SHALL be speech iff energy > ithresh (strict); equality is silence.
REQ-018 The frame base address and frame end address SHALL be the addresses of the frame's first and last samples.
REQ-019 State IDLE: a speech frame latches candidate start = frame base and end = frame end; go to ONSET with on_cnt=1, or directly to WORD if ON_FRAMES=1; silence stays IDLE.
REQ-020 State ONSET: a speech frame increments on_cnt and updates end; on_cnt reaching ON_FRAMES goes to WORD; a silence frame discards the candidate and goes to IDLE.
REQ-021 State WORD: a speech frame updates end to frame end; a silence frame goes to HANG with off_cnt=1.
REQ-022 State HANG: a speech frame updates end and returns to WORD with off_cnt cleared; a silence frame increments off_cnt; off_cnt reaching OFF_FRAMES emits the word and goes to IDLE.
REQ-023 A frame counter SHALL count frames since candidate start; if it reaches MAX_FRAMES in WORD or HANG, the word is emitted with end = last speech frame end and the state goes to IDLE. This takes priority over REQ-021 and REQ-022.
REQ-024 Emit SHALL register ostart_addr/oend_addr and drive ovalid high for exactly the one cycle following the decision edge; the addresses SHALL hold until the next emit.
REQ-025 There SHALL be no backpressure; at most one emit per frame period.
REQ-026 isample_valid low SHALL freeze the accumulator, counters and state; there is no minimum gap between valid samples.
REQ-027 The frame following an emit or force-end SHALL be evaluated from IDLE, so it may start a new word.

Reset
REQ-028 While irst is high at an edge: state IDLE, address counter 0, accumulator 0, all internal counters 0, ovalid 0, obusy 0, ostart_addr 0, oend_addr 0.
REQ-029 Reset mid-word SHALL discard the word with no ovalid; the first sample after reset gets address 0.

Verification (FRAME_LEN=4, ON_FRAMES=2, OFF_FRAMES=2, MAX_FRAMES=8, ithresh=100)
REQ-030 Reset: assert irst for 2 cycles with samples driven -> all outputs 0; the next accepted sample gets address 0.
REQ-031 Basic word: 2 silence frames (0), then 3 frames of +1000, then 2 silence frames. -> ovalid pulses once, the cycle after address 27 is accepted; start=8, end=19.
REQ-032 Blip rejection: 1 frame of -1000 then 4 silence frames -> no ovalid, obusy high for 1 frame only. A frame of four samples of 25 (energy 100 = threshold) is silence.
REQ-033 Gap bridging: speech at addresses 0-7, silence 8-11, speech 12-15, silence 16-23 -> single ovalid; start=0, end=15.
REQ-034 Force-end: continuous +1000 for 10 frames -> ovalid the cycle after address 31 is accepted, start=0, end=31. A new onset begins at address 32, start=32.
REQ-035 Stalls and extremes: random isample_valid gaps plus samples of -32768 -> addresses and ovalid timing identical to gap-free run relative to accepted samples.
